// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: function encoding, field widths,
// the buffered instruction record and operand-usage decoding.
package alu_pkg;

    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;
    localparam int ADDR_W = 8;

    typedef enum logic [FUNC_W-1:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        MOV_A = 4'd3,
        MOV_B = 4'd4,
        OR    = 4'd5,
        XOR   = 4'd6,
        SLT   = 4'd7,
        NOT_A = 4'd8,
        NOT_B = 4'd9,
        INC   = 4'd10,
        SHL   = 4'd11
    } func_e;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // Encodings above SHL are reserved and get dropped at the head
    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return f <= FUNC_W'(SHL);
    endfunction

    function automatic logic uses_rs1(input logic [FUNC_W-1:0] f);
        return f inside {ADD, SUB, AND, MOV_A, OR, XOR, SLT, NOT_A, INC, SHL};
    endfunction

    function automatic logic uses_rs2(input logic [FUNC_W-1:0] f);
        return f inside {ADD, SUB, AND, MOV_B, OR, XOR, SLT, NOT_B};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / op-out bundle of the ALU issue controller.
// master = instruction source and status observer, slave = the controller.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  in_rd;
    logic [FUNC_W-1:0] in_func;
    logic [ADDR_W-1:0] in_addr;
    logic              flush;

    logic              op_valid;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [FUNC_W-1:0] func;
    logic [ADDR_W-1:0] addr;
    logic              err_illegal;
    logic              busy;
    logic [15:0]       issue_cnt;
    logic [15:0]       stall_cnt;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, flush,
        input  in_ready, op_valid, rs1, rs2, rd, func, addr,
               err_illegal, busy, issue_cnt, stall_cnt
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, flush,
        output in_ready, op_valid, rs1, rs2, rd, func, addr,
               err_illegal, busy, issue_cnt, stall_cnt
    );

endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous instruction buffer with occupancy count; flush empties it
// in one edge and takes priority over push/pop.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  instr_t                       din,
    output instr_t                       dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    instr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk1) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// In-order ALU issue stage: buffers instructions, holds a RAW-hazard head until
// its producers age out of the scoreboard. Optional counters: ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int HAZARD_DEPTH = 3
) (
    input  logic            clk1,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    instr_t            in_instr, head, out_q;
    logic              full, empty;
    logic [CNT_W-1:0]  count;
    logic              push, pop, issue, drop, hazard, head_legal;
    logic              op_valid_q, err_q;

    // Scoreboard: sb_vld[i]/sb_rd[i] describe the op issued i+1 edges ago
    logic [HAZARD_DEPTH-1:0]            sb_vld;
    logic [HAZARD_DEPTH-1:0][REG_W-1:0] sb_rd;

    assign in_instr = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                        func: bus.in_func, addr: bus.in_addr};

    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready && !bus.flush;

    alu_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (push),
        .pop   (pop),
        .din   (in_instr),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (sb_vld[i] && ((uses_rs1(head.func) && sb_rd[i] == head.rs1) ||
                              (uses_rs2(head.func) && sb_rd[i] == head.rs2)))
                hazard = 1'b1;
        end
    end

    assign head_legal = func_legal(head.func);
    assign issue      = !empty && !bus.flush && head_legal && !hazard;
    assign drop       = !empty && !bus.flush && !head_legal;
    assign pop        = issue || drop;

    // Keeps shifting through a flush so ops already issued stay tracked
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld <= '0;
            sb_rd  <= '0;
        end else begin
            sb_vld[0] <= issue;
            sb_rd[0]  <= head.rd;
            for (int i = 1; i < HAZARD_DEPTH; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_rd[i]  <= sb_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
            out_q      <= '0;
        end else begin
            op_valid_q <= issue;
            err_q      <= drop;
            if (issue) out_q <= head;
        end
    end

    assign bus.op_valid    = op_valid_q;
    assign bus.err_illegal = err_q;
    assign bus.rs1         = out_q.rs1;
    assign bus.rs2         = out_q.rs2;
    assign bus.rd          = out_q.rd;
    assign bus.func        = out_q.func;
    assign bus.addr        = out_q.addr;
    assign bus.busy        = (count != '0) || (|sb_vld);

`ifdef ALU_ISSUE_PERF_EN
    logic        stall;
    logic [15:0] issue_cnt_q, stall_cnt_q;

    assign stall = !empty && !bus.flush && head_legal && hazard;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && issue_cnt_q != 16'hFFFF) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.issue_cnt = issue_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.issue_cnt = '0;
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed scenarios plus random traffic
// checked against a queue-based issue model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int FD = 4;
    localparam int HD = 3;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.FIFO_DEPTH(FD), .HAZARD_DEPTH(HD)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int     edge_n = 0;
    instr_t mq[$];
    instr_t exp_q[$];
    int     last_iss[16] = '{default: -100};
    int     last_any = -100;
    bit     err_now = 0;
    int     m_issue = 0;
    int     m_stall = 0;
    instr_t m_last = '0;

    int obs_cyc[$];
    int obs_err = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    function automatic bit reads1(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11};
    endfunction

    function automatic bit reads2(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    endfunction

    // A source is blocked while its producer issued within the last HD edges
    function automatic bit blocked(input instr_t h);
        return (reads1(h.func) && (edge_n - last_iss[h.rs1] <= HD)) ||
               (reads2(h.func) && (edge_n - last_iss[h.rs2] <= HD));
    endfunction

    always @(posedge clk1 or negedge rst_n) begin
        bit     ready, pushing;
        instr_t h, inw;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            for (int r = 0; r < 16; r++) last_iss[r] = -100;
            last_any = -100;
            err_now  = 0;
            m_issue  = 0;
            m_stall  = 0;
            m_last   = '0;
        end else begin
            edge_n++;
            ready   = mq.size() < FD;
            pushing = bus.in_valid && ready && !bus.flush;
            inw.rs1 = bus.in_rs1;  inw.rs2 = bus.in_rs2;  inw.rd = bus.in_rd;
            inw.func = bus.in_func; inw.addr = bus.in_addr;
            err_now = 0;
            if (bus.flush) begin
                mq.delete();
            end else if (mq.size() > 0) begin
                h = mq[0];
                if (h.func >= 4'd12) begin
                    void'(mq.pop_front());
                    err_now = 1;
                end else if (blocked(h)) begin
                    if (m_stall < 65535) m_stall++;
                end else begin
                    void'(mq.pop_front());
                    exp_q.push_back(h);
                    last_iss[h.rd] = edge_n;
                    last_any = edge_n;
                    if (m_issue < 65535) m_issue++;
                end
            end
            if (pushing) mq.push_back(inw);
        end
    end

    // Monitor: compare DUT outputs against the model between edges
    always @(negedge clk1) begin
        instr_t e;
        if (bus.op_valid) begin
            obs_cyc.push_back(edge_n);
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("issue_rs1", bus.rs1, e.rs1);
                check("issue_rs2", bus.rs2, e.rs2);
                check("issue_rd", bus.rd, e.rd);
                check("issue_func", bus.func, e.func);
                check("issue_addr", bus.addr, e.addr);
                m_last = e;
            end
        end else begin
            check("missing_issue", exp_q.size(), 0);
            exp_q.delete();
            check("hold_rs1", bus.rs1, m_last.rs1);
            check("hold_rs2", bus.rs2, m_last.rs2);
            check("hold_rd", bus.rd, m_last.rd);
            check("hold_func", bus.func, m_last.func);
            check("hold_addr", bus.addr, m_last.addr);
        end
        if (bus.err_illegal) obs_err++;
        check("err_illegal", bus.err_illegal, err_now);
        check("in_ready", bus.in_ready, (rst_n && mq.size() < FD));
        check("busy", bus.busy, (mq.size() > 0 || (edge_n - last_any < HD)));
`ifdef ALU_ISSUE_PERF_EN
        check("issue_cnt", bus.issue_cnt, m_issue);
        check("stall_cnt", bus.stall_cnt, m_stall);
`else
        check("issue_cnt_off", bus.issue_cnt, 0);
        check("stall_cnt_off", bus.stall_cnt, 0);
`endif
    end

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic push(input logic [3:0] f, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic [7:0] a, output int acc);
        bus.in_valid = 1'b1;
        bus.in_func = f; bus.in_rs1 = s1; bus.in_rs2 = s2; bus.in_rd = d; bus.in_addr = a;
        acc = -1;
        for (int t = 0; t < 100; t++) begin
            if (bus.in_ready) begin
                @(negedge clk1);
                acc = edge_n;
                break;
            end
            @(negedge clk1);
        end
        if (acc < 0) check("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk1);
    endtask

    task automatic do_flush();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk1);
        bus.flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3, a4, base;
        bus.in_valid = 0; bus.flush = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0; bus.in_func = 0; bus.in_addr = 0;

        repeat (3) @(negedge clk1);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk1);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Back-to-back independent ops
        obs_cyc.delete();
        push(4'd0, 4'd2, 4'd3, 4'd1, 8'h10, a0);
        push(4'd5, 4'd5, 4'd6, 4'd4, 8'h11, a1);
        idle(8);
        check("t1_issue_count", obs_cyc.size(), 2);
        if (obs_cyc.size() == 2) begin
            check("t1_first_latency", obs_cyc[0], a0 + 1);
            check("t1_consecutive", obs_cyc[1], obs_cyc[0] + 1);
        end

        // RAW dependency on rs1
        obs_cyc.delete();
        base = bus.stall_cnt;
        push(4'd0, 4'd2, 4'd3, 4'd1, 8'h20, a0);
        push(4'd1, 4'd1, 4'd4, 4'd5, 8'h21, a1);
        idle(10);
        check("t2_issue_count", obs_cyc.size(), 2);
        if (obs_cyc.size() == 2) check("t2_dep_gap", obs_cyc[1] - obs_cyc[0], HD + 1);
`ifdef ALU_ISSUE_PERF_EN
        check("t2_stall_delta", bus.stall_cnt - base, 3);
`endif

        // NOT_B ignores rs1, so no hazard
        obs_cyc.delete();
        push(4'd0, 4'd2, 4'd3, 4'd1, 8'h30, a0);
        push(4'd9, 4'd1, 4'd2, 4'd7, 8'h31, a1);
        idle(8);
        check("t3_issue_count", obs_cyc.size(), 2);
        if (obs_cyc.size() == 2) check("t3_gap", obs_cyc[1] - obs_cyc[0], 1);

        // Illegal op between two legal ones
        obs_cyc.delete();
        obs_err = 0;
        base = bus.issue_cnt;
        push(4'd0, 4'd2, 4'd3, 4'd1, 8'h40, a0);
        push(4'd13, 4'd7, 4'd8, 4'd9, 8'h41, a1);
        push(4'd5, 4'd5, 4'd6, 4'd4, 8'h42, a2);
        idle(8);
        check("t4_err_pulses", obs_err, 1);
        check("t4_issue_count", obs_cyc.size(), 2);
`ifdef ALU_ISSUE_PERF_EN
        check("t4_issue_delta", bus.issue_cnt - base, 2);
`endif

        // Fill behind a stalled head, then flush
        obs_cyc.delete();
        push(4'd0, 4'd2, 4'd3, 4'd1, 8'h50, a0);
        push(4'd1, 4'd1, 4'd4, 4'd5, 8'h51, a1);
        push(4'd0, 4'd8, 4'd9, 4'd10, 8'h52, a2);
        push(4'd0, 4'd8, 4'd9, 4'd11, 8'h53, a3);
        push(4'd0, 4'd8, 4'd9, 4'd12, 8'h54, a4);
        bus.in_valid = 1'b0;
        check("t5_full_in_ready", bus.in_ready, 0);
        check("t5_full_busy", bus.busy, 1);
        do_flush();
        check("t5_flush_in_ready", bus.in_ready, 1);
        idle(8);
        check("t5_only_producer", obs_cyc.size(), 1);
        check("t5_busy_drained", bus.busy, 0);

        // Asynchronous reset mid-stream
        obs_cyc.delete();
        push(4'd0, 4'd2, 4'd3, 4'd1, 8'h60, a0);
        push(4'd1, 4'd1, 4'd4, 4'd5, 8'h61, a1);
        push(4'd2, 4'd6, 4'd7, 4'd8, 8'h62, a2);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_op_valid", bus.op_valid, 0);
        check("t6_rst_rd", bus.rd, 0);
        check("t6_rst_addr", bus.addr, 0);
        check("t6_rst_err", bus.err_illegal, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_in_ready", bus.in_ready, 0);
        check("t6_rst_issue_cnt", bus.issue_cnt, 0);
        check("t6_rst_stall_cnt", bus.stall_cnt, 0);
        repeat (2) @(negedge clk1);
        #2 rst_n = 1'b1;
        obs_cyc.delete();
        @(negedge clk1);
        idle(6);
        check("t6_no_issue_after_rst", obs_cyc.size(), 0);

        // Random traffic on a small register set to provoke hazards
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_flush();
            end else begin
                push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3)), 8'($urandom), a0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, instruction buffer entries; HAZARD_DEPTH, default 3, cycles a destination register stays pending after issue.
REQ-002 clk1  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1 / in_ready  out  1  instruction handshake; transfer when both high at the clk1 edge.
REQ-005 in_rs1, in_rs2, in_rd, in_func  in  4 each / in_addr  in  8  instruction fields.
REQ-006 flush  in  1  synchronous discard of buffered, unissued instructions.
REQ-007 op_valid  out  1  qualifies issued fields for one cycle.
REQ-008 rs1, rs2, rd, func  out  4 each / addr  out  8  issued instruction to the ALU pipeline.
REQ-009 err_illegal  out  1  one-cycle pulse per dropped illegal instruction.
REQ-010 busy  out  1 / issue_cnt  out  16 / stall_cnt  out  16  status and performance counters.

Function
REQ-011 in_ready SHALL equal (FIFO occupancy < FIFO_DEPTH) from registered state; no push-through when full, even if the same edge pops.
REQ-012 Head examination: legal func 0-11; func 12-15 SHALL be popped without issue, pulse err_illegal the next cycle, not enter the scoreboard.
REQ-013 Operand use: rs1 read by func 0,1,2,3,5,6,7,8,10,11; rs2 read by func 0,1,2,4,5,6,7,9.
REQ-014 Scoreboard: HAZARD_DEPTH-entry shift register of {valid, rd}, shifted every edge; entry 0 loaded with {issue, rd}.
REQ-015 Hazard: legal head SHALL stall while any used source equals rd of any valid scoreboard entry; otherwise it issues and pops at that edge.
REQ-016 Issue timing: op accepted at edge N issues at edge N+1 at earliest; independent ops issue one per cycle.
REQ-017 Dependent op after producer issued at edge k SHALL issue at edge k+HAZARD_DEPTH+1 at earliest (3 idle cycles with default).
REQ-018 Outputs registered; on non-issue cycles op_valid=0 and rs1/rs2/rd/func/addr hold last issued values.
REQ-019 flush: FIFO emptied at that edge; no issue and no push that edge; scoreboard keeps shifting (in-flight ops remain tracked).
REQ-020 busy SHALL be 1 while FIFO non-empty or any scoreboard entry valid.
REQ-021 issue_cnt +1 per issue; stall_cnt +1 per cycle a legal head is hazard-stalled; both saturate at 16'hFFFF.
REQ-022 Order SHALL be strictly in-order; no instruction bypasses a stalled head.

Reset
REQ-023 rst_n low SHALL immediately clear FIFO, scoreboard, counters; all outputs 0; in_ready 1 after release.
REQ-024 Reset mid-operation SHALL discard buffered and pending state without issuing.

Configuration
REQ-025 Macro ALU_ISSUE_PERF_EN: defined -> issue_cnt/stall_cnt per REQ-021; undefined -> counter logic absent, both ports tied to 0; all other behaviour identical.

Structure
REQ-026 Package alu_pkg SHALL hold the func encoding enum (ADD=0 ... SHL=11), reg/addr width constants, and an instruction struct {rs1, rs2, rd, func, addr}.
REQ-027 Sub-module alu_issue_fifo (synchronous FIFO of the instruction struct, full/empty/count) SHALL hold the buffer.

Verification
REQ-028 Push ADD r1=r2+r3 then OR r4=r5|r6 back-to-back -> op_valid on two consecutive cycles, first one edge after acceptance.
REQ-029 Issue ADD rd=1 at edge k, then SUB rs1=1 -> SUB issues at edge k+4; stall_cnt=3 (PERF_EN).
REQ-030 Issue ADD rd=1, then NOT_B (func 9) rs1=1 rs2=2 -> no stall, issues next cycle.
REQ-031 Push func=13 between two legal ops -> err_illegal pulses once, only two op_valid pulses, issue_cnt=2.
REQ-032 Fill 4 entries behind a stalled head -> in_ready=0; assert flush -> FIFO empty, no issue, busy falls after scoreboard drains.
REQ-033 Assert rst_n low mid-stream -> outputs 0 immediately, no op_valid after release until new push.
